// File: rtl/rx_mac_if.sv
// rx_mac_if: MII receive pins plus the user-side payload stream
interface rx_mac_if;
  logic       mii_rx_dv;
  logic       mii_rx_er;
  logic [3:0] mii_rx_dat;
  logic       rx_vld;
  logic [3:0] rx_dat;
  logic       rx_eof;
  logic       rx_good;
  modport master (output mii_rx_dv, mii_rx_er, mii_rx_dat, input rx_vld, rx_dat, rx_eof, rx_good);
  modport slave (input mii_rx_dv, mii_rx_er, mii_rx_dat, output rx_vld, rx_dat, rx_eof, rx_good);
endinterface

// File: rtl/rx_mac.sv
// rx_mac: MII receive MAC stripping preamble/SFD and FCS, checking CRC and length
module rx_mac #(
  parameter int MAX_NIBBLES = 3036,
  parameter int MIN_NIBBLES = 128
) (
  input logic    clk_rx,
  input logic    rst,
  rx_mac_if.slave m
);
  typedef enum logic [2:0] {IDLE, PRE, DATA, EOF, DROP} state_t;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;
  localparam logic [11:0] MAX_C = 12'(MAX_NIBBLES);
  localparam logic [11:0] MIN_C = 12'(MIN_NIBBLES);
  state_t      r_state, w_next;
  logic        r_dv, r_er, r_arm, r_bad;
  logic [3:0]  r_dat;
  logic [31:0] r_crc, w_crc, r_dl;
  logic [11:0] r_cnt;
  logic        w_start, w_take, w_end, w_good;
  // one register stage on the PHY pins before any decision is made
  always_ff @(posedge clk_rx) begin
    r_dv  <= m.mii_rx_dv;
    r_er  <= m.mii_rx_er;
    r_dat <= m.mii_rx_dat;
  end
  // four serial CRC steps per nibble, bit 0 first
  always_comb begin
    w_crc = r_crc;
    for (int i = 0; i < 4; i++) w_crc = {w_crc[30:0], 1'b0} ^ ((r_dat[i] ^ w_crc[31]) ? POLY : 32'h0);
  end
  // next-state decode; r_arm keeps IDLE deaf after reset until the line has gone quiet
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (r_dv && r_arm) w_next = (r_dat == 4'h5) ? PRE : DROP;
      PRE:     w_next = !r_dv ? IDLE : r_er ? DROP : (r_dat == 4'h5) ? PRE : (r_dat == 4'hD) ? DATA : DROP;
      DATA:    if (!r_dv) w_next = EOF;
      EOF:     w_next = IDLE;
      DROP:    if (!r_dv) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    w_start = (r_state == PRE) && (w_next == DATA);
    w_take  = (r_state == DATA) && r_dv;
    w_end   = (r_state == DATA) && !r_dv;
    w_good  = (r_crc == RESIDUE) && !r_cnt[0] && (r_cnt >= MIN_C) && (r_cnt <= MAX_C) && !r_bad;
  end
  // state register and the post-reset arming flag
  always_ff @(posedge clk_rx) begin
    if (rst) begin
      r_state <= IDLE;
      r_arm   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_arm   <= r_arm | !r_dv;
    end
  end
  // CRC, saturating length counter, 8-nibble delay line and registered user outputs
  always_ff @(posedge clk_rx) begin
    if (rst) begin
      r_crc     <= '1;
      r_cnt     <= '0;
      r_dl      <= '0;
      r_bad     <= 1'b0;
      m.rx_vld  <= 1'b0;
      m.rx_dat  <= 4'h0;
      m.rx_eof  <= 1'b0;
      m.rx_good <= 1'b0;
    end else begin
      m.rx_vld  <= w_take && (r_cnt >= 12'd8) && (r_cnt < MAX_C);
      m.rx_dat  <= r_dl[31:28];
      m.rx_eof  <= w_end;
      m.rx_good <= w_end && w_good;
      if (w_start) begin
        r_crc <= '1;
        r_cnt <= '0;
        r_dl  <= '0;
        r_bad <= 1'b0;
      end else if (w_take) begin
        r_crc <= w_crc;
        r_cnt <= (r_cnt > MAX_C) ? r_cnt : r_cnt + 12'd1;
        r_dl  <= {r_dl[27:0], r_dat};
        r_bad <= r_bad | r_er;
      end
    end
  end
endmodule

// File: tb/tb_rx_mac.sv
// tb_rx_mac: scoreboard bench for rx_mac using reflected Ethernet CRC for FCS generation
module tb_rx_mac;
  logic clk_rx = 1'b0;
  logic rst = 1'b1;
  rx_mac_if bus();
  rx_mac dut (.clk_rx(clk_rx), .rst(rst), .m(bus));
  always #20 clk_rx = ~clk_rx;
  int checks = 0, failures = 0, cyc = 0, eofs = 0, t_drv = -1, t_vld = -1;
  logic [3:0] nibs[$];
  logic [3:0] exp_nib[$];
  bit exp_good[$];
  always @(posedge clk_rx) cyc <= cyc + 1;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk_rx) begin
    if (bus.rx_vld === 1'b1) begin
      if (t_vld < 0) t_vld = cyc;
      chk("nib_avail", 32'(exp_nib.size() != 0), 1);
      if (exp_nib.size() != 0) chk("rx_dat", 32'(bus.rx_dat), 32'(exp_nib.pop_front()));
    end
    if (bus.rx_eof === 1'b1) begin
      eofs++;
      chk("eof_no_vld", 32'(bus.rx_vld), 0);
      chk("eof_avail", 32'(exp_good.size() != 0), 1);
      if (exp_good.size() != 0) chk("rx_good", 32'(bus.rx_good), 32'(exp_good.pop_front()));
    end
  end
  task automatic drv(logic dv, logic er, logic [3:0] d);
    @(posedge clk_rx);
    #1;
    bus.mii_rx_dv  = dv;
    bus.mii_rx_er  = er;
    bus.mii_rx_dat = d;
  endtask
  task automatic build(int nbytes);
    logic [31:0] crc;
    logic [7:0] b;
    crc = '1;
    nibs.delete();
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom);
      nibs.push_back(b[3:0]);
      nibs.push_back(b[7:4]);
      crc ^= {24'h0, b};
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    crc = ~crc;
    for (int k = 0; k < 4; k++) begin
      b = crc[8*k +: 8];
      nibs.push_back(b[3:0]);
      nibs.push_back(b[7:4]);
    end
  endtask
  task automatic send(int nout, int good, int er_at, int rst_at, int gap);
    for (int i = 0; i < nout; i++) exp_nib.push_back(nibs[i]);
    if (good >= 0) exp_good.push_back(good[0]);
    repeat (15) drv(1'b1, 1'b0, 4'h5);
    drv(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < nibs.size(); i++) begin
      drv(1'b1, i == er_at, nibs[i]);
      if (i == 0) t_drv = cyc;
      if (i == rst_at) rst = 1'b1;
      else if (rst_at >= 0 && i == rst_at + 1) begin
        chk("rst_mid_vld", 32'(bus.rx_vld), 0);
        chk("rst_mid_eof", 32'(bus.rx_eof), 0);
        chk("rst_mid_good", 32'(bus.rx_good), 0);
        rst = 1'b0;
      end
    end
    repeat (gap) drv(1'b0, 1'b0, 4'h0);
  endtask
  initial begin
    bus.mii_rx_dv  = 1'b0;
    bus.mii_rx_er  = 1'b0;
    bus.mii_rx_dat = 4'h0;
    repeat (3) drv(1'b0, 1'b0, 4'h0);
    rst = 1'b0;
    chk("rst_vld", 32'(bus.rx_vld), 0);
    chk("rst_dat", 32'(bus.rx_dat), 0);
    chk("rst_eof", 32'(bus.rx_eof), 0);
    chk("rst_good", 32'(bus.rx_good), 0);
    repeat (2) drv(1'b0, 1'b0, 4'h0);
    build(60);
    send(120, 1, -1, -1, 4);
    chk("latency", 32'(t_vld - t_drv), 10);
    build(60);
    nibs[40] ^= 4'h1;
    send(120, 0, -1, -1, 4);
    build(60);
    send(120, 0, 30, -1, 4);
    build(60);
    void'(nibs.pop_back());
    send(119, 0, -1, -1, 4);
    build(1516);
    send(3028, 0, -1, -1, 4);
    drv(1'b1, 1'b0, 4'h5);
    drv(1'b1, 1'b0, 4'h5);
    drv(1'b1, 1'b0, 4'h7);
    repeat (3) drv(1'b1, 1'b0, 4'h5);
    drv(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < 20; i++) drv(1'b1, 1'b0, 4'($urandom));
    repeat (4) drv(1'b0, 1'b0, 4'h0);
    nibs = '{4'h1, 4'h2, 4'h3, 4'h4};
    send(0, 0, -1, -1, 4);
    build(60);
    send(41, -1, -1, 50, 4);
    build(60);
    send(120, 1, -1, -1, 4);
    build(60);
    send(120, 1, -1, -1, 1);
    build(60);
    send(120, 1, -1, -1, 4);
    repeat (10) drv(1'b0, 1'b0, 4'h0);
    chk("nib_left", 32'(exp_nib.size()), 0);
    chk("eof_left", 32'(exp_good.size()), 0);
    chk("eof_count", 32'(eofs), 9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
